// File: rtl/multiply_iter.sv
// multiply_iter: iterative multiplier for the execute stage covering the
// RISC-V M-extension multiply group (MUL, MULH, MULHSU, MULHU).
//
// Operands are converted to magnitudes. STEP_BITS bits of |b| are retired
// per CALC cycle into a 2*XLEN accumulator. The sign is applied once in FIX.
// A one-entry cache keeps the last full product, so a MULH/MUL pair on the
// same operands pays for one multiply only.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   a, b      multiplicand / multiplier, sampled when stb is accepted
//   a_signed  treat a as two's complement
//   b_signed  treat b as two's complement
//   hi        1: return upper product half, 0: lower half
//   stb       request, accepted only while ready=1
//   ready     idle and able to accept stb
//   kill      abort the in-flight operation (pipeline flush)
//   o         selected result half, valid from ack until the next accept
//   ack       one-cycle completion pulse
module multiply_iter #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 2,
  parameter int USE_CACHE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            a_signed,
  input  logic            b_signed,
  input  logic            hi,
  input  logic            stb,
  output logic            ready,
  input  logic            kill,
  output logic [XLEN-1:0] o,
  output logic            ack
);

  localparam int STEPS = XLEN / STEP_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, HIT} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic                as_q, as_d, bs_q, bs_d;
  logic                hi_q, hi_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     o_q, o_d;
  logic                ack_q, ack_d;
  logic                cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]     cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic                cache_as_q, cache_as_d, cache_bs_q, cache_bs_d;
  logic [2*XLEN-1:0]   cache_prod_q, cache_prod_d;

  logic                a_neg, b_neg, cache_hit, accept;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN+STEP_BITS-1:0] pp;
  logic [2*XLEN-1:0]   partial, product;

  assign ready = (state_q == IDLE);
  assign o     = o_q;
  assign ack   = ack_q;

  // Magnitudes fit in XLEN unsigned bits: -2^(XLEN-1) negates to the bit
  // pattern 2^(XLEN-1), which is the correct unsigned magnitude.
  always_comb begin
    a_neg = a_signed & a[XLEN-1];
    b_neg = b_signed & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    accept = stb & ~kill;
    cache_hit = (USE_CACHE != 0) && cache_valid_q &&
                (a == cache_a_q) && (b == cache_b_q) &&
                (a_signed == cache_as_q) && (b_signed == cache_bs_q);
  end

  // |a| times the low STEP_BITS of the shifting multiplier. The result is
  // placed at the bit position of the current step.
  always_comb begin
    pp = '0;
    for (int j = 0; j < STEP_BITS; j++) begin
      if (mb_q[j]) pp = pp + ((XLEN+STEP_BITS)'(ma_q) << j);
    end
    partial = (2*XLEN)'(pp) << (int'(cnt_q) * STEP_BITS);
    product = neg_q ? -acc_q : acc_q;
  end

  // Next-state logic for the whole datapath and control.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    as_d          = as_q;
    bs_d          = bs_q;
    hi_d          = hi_q;
    neg_d         = neg_q;
    ma_d          = ma_q;
    mb_d          = mb_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    o_d           = o_q;
    ack_d         = 1'b0;
    cache_valid_d = cache_valid_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_as_d    = cache_as_q;
    cache_bs_d    = cache_bs_q;
    cache_prod_d  = cache_prod_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          hi_d = hi;
          if (cache_hit) begin
            state_d = HIT;
          end else begin
            a_d     = a;
            b_d     = b;
            as_d    = a_signed;
            bs_d    = b_signed;
            neg_d   = a_neg ^ b_neg;
            ma_d    = a_mag;
            mb_d    = b_mag;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + partial;
          mb_d  = mb_q >> STEP_BITS;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!kill) begin
          o_d   = hi_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
          ack_d = 1'b1;
          if (USE_CACHE != 0) begin
            cache_valid_d = 1'b1;
            cache_a_d     = a_q;
            cache_b_d     = b_q;
            cache_as_d    = as_q;
            cache_bs_d    = bs_q;
            cache_prod_d  = product;
          end
        end
      end
      HIT: begin
        state_d = IDLE;
        if (!kill) begin
          o_d   = hi_q ? cache_prod_q[2*XLEN-1:XLEN] : cache_prod_q[XLEN-1:0];
          ack_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset takes priority over stb and kill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      as_q          <= 1'b0;
      bs_q          <= 1'b0;
      hi_q          <= 1'b0;
      neg_q         <= 1'b0;
      ma_q          <= '0;
      mb_q          <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      o_q           <= '0;
      ack_q         <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_as_q    <= 1'b0;
      cache_bs_q    <= 1'b0;
      cache_prod_q  <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      as_q          <= as_d;
      bs_q          <= bs_d;
      hi_q          <= hi_d;
      neg_q         <= neg_d;
      ma_q          <= ma_d;
      mb_q          <= mb_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      o_q           <= o_d;
      ack_q         <= ack_d;
      cache_valid_q <= cache_valid_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_as_q    <= cache_as_d;
      cache_bs_q    <= cache_bs_d;
      cache_prod_q  <= cache_prod_d;
    end
  end

endmodule

// File: tb/tb_multiply_iter.sv
// tb_multiply_iter: self-checking bench for multiply_iter.
// Four instances cover STEP_BITS=2/1/4 with the cache enabled, plus
// STEP_BITS=2 with the cache removed. Instance 0 also runs the directed
// sequences: table vectors, kill, and reset corner cases.
module tb_multiply_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_in[4], b_in[4], o_w[4];
  logic        as_in[4], bs_in[4], hi_in[4], stb_in[4], kill_in[4];
  logic        ready_w[4], ack_w[4];

  int checks_total  = 0;
  int checks_passed = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    multiply_iter #(
      .XLEN(32),
      .STEP_BITS(g == 1 ? 1 : (g == 2 ? 4 : 2)),
      .USE_CACHE(g == 3 ? 0 : 1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .a(a_in[g]),
      .b(b_in[g]),
      .a_signed(as_in[g]),
      .b_signed(bs_in[g]),
      .hi(hi_in[g]),
      .stb(stb_in[g]),
      .ready(ready_w[g]),
      .kill(kill_in[g]),
      .o(o_w[g]),
      .ack(ack_w[g])
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        as;
    logic        bs;
    logic        hi;
    logic [31:0] exp_o;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  // Reference: exact 64-bit product from sign- or zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic xs, input logic ys, input logic h);
    longint sx, sy;
    logic [63:0] p;
    sx = xs ? longint'($signed(x)) : longint'({32'd0, x});
    sy = ys ? longint'($signed(y)) : longint'({32'd0, y});
    p  = 64'(sx * sy);
    return h ? p[63:32] : p[31:0];
  endfunction

  function automatic int miss_lat(input int idx);
    case (idx)
      1:       return 33;
      2:       return 9;
      default: return 17;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'h1;
      2:       v = 32'hFFFFFFFF;
      3:       v = 32'h80000000;
      4:       v = 32'h7FFFFFFF;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Called at a point 1 time unit after a rising edge. Issues one request,
  // waits for its ack and returns the result and the stb-to-ack latency.
  task automatic applyStimulus(input int idx, input logic [31:0] x, input logic [31:0] y,
                               input logic xs, input logic ys, input logic h,
                               output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (ready_w[idx] !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("ready before stb", 64'(ready_w[idx]), 64'(1));
    a_in[idx]   = x;
    b_in[idx]   = y;
    as_in[idx]  = xs;
    bs_in[idx]  = ys;
    hi_in[idx]  = h;
    stb_in[idx] = 1'b1;
    @(posedge clk); #1;
    stb_in[idx] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack_w[idx] !== 1'b1 && lat < 100);
    res = o_w[idx];
    checkOutput("ready with ack", 64'(ready_w[idx]), 64'(1));
  endtask

  task automatic count_acks(input int idx, input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (ack_w[idx] === 1'b1) n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] res, prev_o, xa, xb, exp_x;
    int lat, n;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 17};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001, 1};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000, 17};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 1};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 17};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001, 1};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h00000001, 17};
    vecs[7] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 1'b0, 32'hFFFFFFEB, 17};
    vecs[8] = '{32'h00000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h00000000, 17};
    vecs[9] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 17};

    for (int i = 0; i < 4; i++) begin
      a_in[i] = '0; b_in[i] = '0; as_in[i] = 1'b0; bs_in[i] = 1'b0;
      hi_in[i] = 1'b0; stb_in[i] = 1'b0; kill_in[i] = 1'b0;
    end

    // Reset state on every instance.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reset ready[%0d]", i), 64'(ready_w[i]), 64'(1));
      checkOutput($sformatf("reset ack[%0d]", i), 64'(ack_w[i]), 64'(0));
      checkOutput($sformatf("reset o[%0d]", i), 64'(o_w[i]), 64'(0));
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors, issued back-to-back on instance 0.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, vecs[i].hi, res, lat);
      checkOutput($sformatf("vec%0d o", i), 64'(res), 64'(vecs[i].exp_o));
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
    end
    @(posedge clk); #1;
    checkOutput("ack single cycle", 64'(ack_w[0]), 64'(0));

    // Kill at CALC cycle 5: no ack, ready next cycle, o held.
    xa = 32'h12345678;
    xb = 32'h9ABCDEF0;
    exp_x = ref_mul(xa, xb, 1'b0, 1'b0, 1'b1);
    prev_o = o_w[0];
    a_in[0] = xa; b_in[0] = xb; as_in[0] = 1'b0; bs_in[0] = 1'b0; hi_in[0] = 1'b1;
    stb_in[0] = 1'b1;
    @(posedge clk); #1;
    stb_in[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    kill_in[0] = 1'b1;
    @(posedge clk); #1;
    kill_in[0] = 1'b0;
    checkOutput("kill calc ready", 64'(ready_w[0]), 64'(1));
    checkOutput("kill calc ack", 64'(ack_w[0]), 64'(0));
    checkOutput("kill calc o hold", 64'(o_w[0]), 64'(prev_o));
    count_acks(0, 20, n);
    checkOutput("kill calc ack count", 64'(n), 64'(0));

    // Cache must be untouched by the killed request.
    applyStimulus(0, vecs[9].a, vecs[9].b, vecs[9].as, vecs[9].bs, 1'b1, res, lat);
    checkOutput("post-kill hit o", 64'(res), 64'(32'hFFFFFFFF));
    checkOutput("post-kill hit latency", 64'(lat), 64'(1));

    // Kill during HIT suppresses the ack and holds o.
    a_in[0] = vecs[9].a; b_in[0] = vecs[9].b; as_in[0] = 1'b1; bs_in[0] = 1'b0;
    hi_in[0] = 1'b0; stb_in[0] = 1'b1;
    @(posedge clk); #1;
    stb_in[0] = 1'b0;
    kill_in[0] = 1'b1;
    @(posedge clk); #1;
    kill_in[0] = 1'b0;
    checkOutput("kill hit ack", 64'(ack_w[0]), 64'(0));
    checkOutput("kill hit o hold", 64'(o_w[0]), 64'(32'hFFFFFFFF));

    // The killed operands were never cached, so they miss.
    applyStimulus(0, xa, xb, 1'b0, 1'b0, 1'b1, res, lat);
    checkOutput("killed ops o", 64'(res), 64'(exp_x));
    checkOutput("killed ops latency", 64'(lat), 64'(17));

    // Kill and stb together in IDLE: request dropped.
    a_in[0] = 32'h3; b_in[0] = 32'h5; stb_in[0] = 1'b1; kill_in[0] = 1'b1;
    @(posedge clk); #1;
    stb_in[0] = 1'b0; kill_in[0] = 1'b0;
    checkOutput("kill idle ready", 64'(ready_w[0]), 64'(1));
    count_acks(0, 20, n);
    checkOutput("kill idle ack count", 64'(n), 64'(0));

    // Reset mid-CALC clears outputs and invalidates the cache.
    a_in[0] = 32'h5; b_in[0] = 32'h6; as_in[0] = 1'b1; bs_in[0] = 1'b1; stb_in[0] = 1'b1;
    @(posedge clk); #1;
    stb_in[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("rst calc ready", 64'(ready_w[0]), 64'(1));
    checkOutput("rst calc ack", 64'(ack_w[0]), 64'(0));
    checkOutput("rst calc o", 64'(o_w[0]), 64'(0));
    applyStimulus(0, xa, xb, 1'b0, 1'b0, 1'b0, res, lat);
    checkOutput("post-rst o", 64'(res), 64'(ref_mul(xa, xb, 1'b0, 1'b0, 1'b0)));
    checkOutput("post-rst latency", 64'(lat), 64'(17));

    // Randomised back-to-back streams on every instance.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int idx = 0; idx < 4; idx++) begin
      logic [31:0] ra, rb, ca, cb;
      logic ras, rbs, rh, cas, cbs, cv, exp_hit;
      cv = 1'b0; ca = '0; cb = '0; cas = 1'b0; cbs = 1'b0;
      ra = '0; rb = '0; ras = 1'b0; rbs = 1'b0;
      for (int k = 0; k < 250; k++) begin
        n = int'($urandom_range(0, 7));
        if (k == 0 || n >= 3) begin
          ra = pick_operand();
          rb = pick_operand();
          ras = 1'($urandom_range(0, 1));
          rbs = 1'($urandom_range(0, 1));
        end else if (n == 2) begin
          ras = 1'($urandom_range(0, 1));
          rbs = 1'($urandom_range(0, 1));
        end
        rh = 1'($urandom_range(0, 1));
        exp_hit = (idx != 3) && cv && ra == ca && rb == cb && ras == cas && rbs == cbs;
        applyStimulus(idx, ra, rb, ras, rbs, rh, res, lat);
        checkOutput($sformatf("rand%0d.%0d o", idx, k), 64'(res),
                    64'(ref_mul(ra, rb, ras, rbs, rh)));
        checkOutput($sformatf("rand%0d.%0d latency", idx, k), 64'(lat),
                    64'(exp_hit ? 1 : miss_lat(idx)));
        cv = 1'b1; ca = ra; cb = rb; cas = ras; cbs = rbs;
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
